// File: rtl/dmem_responder.sv
// Data-memory responder: two-lane load/store front end with a direct-mapped,
// write-through, no-write-allocate cache and a single-outstanding bus master.
module dmem_responder #(
  parameter int INDEX_BITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       write_ena,
  input  logic [1:0]       read_ena,
  input  logic [1:0][2:0]  mem_type,
  input  logic [1:0][31:0] addr,
  input  logic [1:0][31:0] write_data,
  output logic [1:0][31:0] read_data,
  output logic [1:0]       read_valid,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ack
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {IDLE, BUS_WAIT} state_t;

  // Select byte/half by the low address bits, then sign- or zero-extend.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  mtype,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (mtype)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {24'd0, b};
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [LINES-1:0]       line_valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];
  logic [1:0]             done_q;
  logic [1:0][31:0]       res_q;
  logic                   lane_q;

  logic [1:0]                  active, is_load, tag_hit, hit_now, need;
  logic [1:0][INDEX_BITS-1:0]  idx;
  logic [1:0][TAG_W-1:0]       tag;
  logic                        lane0_ok;

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      active[i]  = read_ena[i] | write_ena[i];
      is_load[i] = read_ena[i] & ~write_ena[i];
      idx[i]     = addr[i][INDEX_BITS+1:2];
      tag[i]     = addr[i][31:INDEX_BITS+2];
      tag_hit[i] = line_valid[idx[i]] && (tag_mem[idx[i]] == tag[i]);
    end
    hit_now[0] = is_load[0] & tag_hit[0] & ~done_q[0];
    lane0_ok   = ~active[0] | done_q[0] | hit_now[0];
    hit_now[1] = is_load[1] & tag_hit[1] & ~done_q[1] & lane0_ok;
    need[0]    = active[0] & ~done_q[0] & ~hit_now[0];
    need[1]    = active[1] & ~done_q[1] & ~hit_now[1] & lane0_ok;
    read_valid = ~active | done_q | hit_now;
    for (int i = 0; i < 2; i++) begin
      read_data[i] = 32'd0;
      if (done_q[i])       read_data[i] = res_q[i];
      else if (hit_now[i]) read_data[i] = extract(data_mem[idx[i]], mem_type[i], addr[i][1:0]);
    end
  end

  // Bus fields for the lane about to be issued (lane 0 wins when both need it).
  logic        sel;
  logic [2:0]  sel_type;
  logic [1:0]  sel_off;
  logic [31:0] sel_wd, st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    sel      = ~need[0];
    sel_type = mem_type[sel];
    sel_off  = addr[sel][1:0];
    sel_wd   = write_data[sel];
    if (sel_type[2]) begin
      st_wdata = sel_wd;
      st_wstrb = 4'b1111;
    end else if (sel_type[1]) begin
      st_wdata = {2{sel_wd[15:0]}};
      st_wstrb = sel_off[1] ? 4'b1100 : 4'b0011;
    end else begin
      st_wdata = {4{sel_wd[7:0]}};
      st_wstrb = 4'b0001 << sel_off;
    end
  end

  logic                  start, ack_fire, ack_tag_hit;
  logic [INDEX_BITS-1:0] ack_idx;
  logic [TAG_W-1:0]      ack_tag;
  logic [31:0]           merged;

  always_comb begin
    start       = (state_q == IDLE) && (|need);
    ack_fire    = (state_q == BUS_WAIT) && bus_ack;
    ack_idx     = bus_addr[INDEX_BITS+1:2];
    ack_tag     = bus_addr[31:INDEX_BITS+2];
    ack_tag_hit = line_valid[ack_idx] && (tag_mem[ack_idx] == ack_tag);
    merged      = data_mem[ack_idx];
    for (int b = 0; b < 4; b++)
      if (bus_wstrb[b]) merged[8*b +: 8] = bus_wdata[8*b +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)   state_d = BUS_WAIT;
      BUS_WAIT: if (bus_ack) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_wstrb  <= 4'd0;
      lane_q     <= 1'b0;
      done_q     <= 2'b00;
      res_q      <= '0;
      line_valid <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= write_ena[sel];
        bus_addr  <= {addr[sel][31:2], 2'b00};
        bus_wdata <= write_ena[sel] ? st_wdata : 32'd0;
        bus_wstrb <= write_ena[sel] ? st_wstrb : 4'd0;
        lane_q    <= sel;
      end else if (ack_fire) begin
        bus_req <= 1'b0;
      end
      if (read_valid == 2'b11) begin
        done_q <= 2'b00;
      end else if (ack_fire) begin
        done_q[lane_q] <= 1'b1;
        res_q[lane_q]  <= bus_we ? 32'd0
                                 : extract(bus_rdata, mem_type[lane_q], addr[lane_q][1:0]);
      end
      if (ack_fire && !bus_we) line_valid[ack_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; line_valid alone marks them
  // meaningful, which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (ack_fire) begin
      if (!bus_we) begin
        tag_mem[ack_idx]  <= ack_tag;
        data_mem[ack_idx] <= bus_rdata;
      end else if (ack_tag_hit) begin
        data_mem[ack_idx] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: transaction-level cache/memory model,
// bus responder with programmable ack delay, per-cycle read_valid/data compare.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       write_ena, read_ena;
  logic [1:0][2:0]  mem_type;
  logic [1:0][31:0] addr, write_data;
  logic [1:0][31:0] read_data;
  logic [1:0]       read_valid;
  logic             bus_req, bus_we;
  logic [31:0]      bus_addr, bus_wdata, bus_rdata;
  logic [3:0]       bus_wstrb;
  logic             bus_ack;

  dmem_responder #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .write_ena(write_ena), .read_ena(read_ena),
    .mem_type(mem_type), .addr(addr), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_op_t;

  bus_op_t exp_ops[$];
  bus_op_t got_ops[$];

  // Backing memory as seen by the bus responder and, separately, by the model.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    if (a == 32'h300) return 32'h80FF7F01;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mmem_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  // Model cache: 64 one-word lines, tag = addr >> 8.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64];

  function automatic int size_of(input logic [2:0] mt);
    if (mt <= 1) return 1;
    if (mt <= 3) return 2;
    return 4;
  endfunction

  function automatic int off_of(input int nbytes, input logic [31:0] a);
    if (nbytes == 4) return 0;
    if (nbytes == 2) return (a % 4) / 2 * 2;
    return a % 4;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [2:0] mt,
                                            input logic [31:0] a);
    int          nb, off;
    logic [31:0] v, mask;
    nb   = size_of(mt);
    off  = off_of(nb, a);
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    v    = (w >> (8 * off)) & mask;
    if ((mt == 0 || mt == 2) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One lane's access applied in program order to the model.
  task automatic model_lane(input logic we, input logic re, input logic [2:0] mt,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] res);
    int          nb, off, i;
    logic [31:0] wa, t, data, w;
    logic [3:0]  strb;
    bus_op_t     op;
    res = 32'd0;
    wa  = a & ~32'h3;
    i   = (a >> 2) % 64;
    t   = a >> 8;
    if (we) begin
      nb   = size_of(mt);
      off  = off_of(nb, a);
      strb = 4'(((1 << nb) - 1) << off);
      data = (nb == 4) ? wd : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
      op.we = 1'b1; op.addr = wa; op.wdata = data; op.wstrb = strb;
      exp_ops.push_back(op);
      w = mmem_rd(wa);
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      mmem[wa] = w;
      if (m_valid[i] && m_tag[i] == t) m_data[i] = w;
    end else if (re) begin
      if (m_valid[i] && m_tag[i] == t) begin
        w = m_data[i];
      end else begin
        op.we = 1'b0; op.addr = wa; op.wdata = 32'd0; op.wstrb = 4'd0;
        exp_ops.push_back(op);
        w = mmem_rd(wa);
        m_valid[i] = 1'b1; m_tag[i] = t; m_data[i] = w;
      end
      res = m_extract(w, mt, a);
    end
  endtask

  // Shared state between the driver, the compare process and the responder.
  int               ack_delay = 0;
  int               cyc       = 0;
  int               exp_cyc   = 0;
  bit               chk_en    = 1'b0;
  bit               txn_done  = 1'b0;
  string            cur_name  = "";
  logic [1:0][31:0] exp_data;
  logic [1:0][31:0] obs_data;

  // Compare process: read_valid==11 must appear exactly at the model's cycle,
  // with the model's data on every load lane.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check($sformatf("%s rv11@c%0d", cur_name, cyc), read_valid == 2'b11, cyc == exp_cyc);
      if (read_valid == 2'b11) begin
        for (int l = 0; l < 2; l++)
          if (read_ena[l] && !write_ena[l])
            check($sformatf("%s data%0d", cur_name, l), read_data[l], exp_data[l]);
        obs_data = read_data;
        txn_done = 1'b1;
        chk_en   = 1'b0;
      end
      cyc++;
    end
  end

  // Bus responder: acks after ack_delay extra cycles, and checks that a pending
  // request holds every field stable.
  int          wait_cnt = 0;
  bit          held_v   = 1'b0;
  logic        held_we;
  logic [31:0] held_addr, held_wdata;
  logic [3:0]  held_wstrb;

  always @(negedge clk) begin
    if (rst) begin
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      wait_cnt  = 0;
      held_v    = 1'b0;
    end else begin
      if (bus_req && held_v && !bus_ack) begin
        check("bus_stable_addr", bus_addr, held_addr);
        check("bus_stable_wdata", bus_wdata, held_wdata);
        check("bus_stable_we_strb", {bus_we, bus_wstrb}, {held_we, held_wstrb});
      end
      held_v = bus_req; held_we = bus_we; held_addr = bus_addr;
      held_wdata = bus_wdata; held_wstrb = bus_wstrb;
      if (bus_ack) begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
      end else if (bus_req) begin
        if (wait_cnt >= ack_delay) begin
          bus_op_t     op;
          logic [31:0] w;
          op.we = bus_we; op.addr = bus_addr; op.wdata = bus_wdata; op.wstrb = bus_wstrb;
          got_ops.push_back(op);
          w = bmem_rd(bus_addr);
          if (bus_we) begin
            for (int b = 0; b < 4; b++) if (bus_wstrb[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
            bmem[bus_addr] = w;
          end else begin
            bus_rdata = w;
          end
          bus_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic set_idle();
    write_ena = 2'b00; read_ena = 2'b00;
    mem_type  = '0; addr = '0; write_data = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the lanes idle again.
  task automatic run(input string name, input logic [1:0] we, input logic [1:0] re,
                     input logic [2:0] mt0, input logic [31:0] a0, input logic [31:0] wd0,
                     input logic [2:0] mt1, input logic [31:0] a1, input logic [31:0] wd1,
                     input int delay);
    logic [31:0] r0, r1;
    write_ena = we; read_ena = re;
    mem_type[0] = mt0; addr[0] = a0; write_data[0] = wd0;
    mem_type[1] = mt1; addr[1] = a1; write_data[1] = wd1;
    ack_delay = delay;
    exp_ops.delete();
    got_ops.delete();
    model_lane(we[0], re[0], mt0, a0, wd0, r0);
    model_lane(we[1], re[1], mt1, a1, wd1, r1);
    exp_data[0] = r0; exp_data[1] = r1;
    exp_cyc  = exp_ops.size() * (delay + 2);
    cur_name = name;
    cyc      = 0;
    txn_done = 1'b0;
    chk_en   = 1'b1;
    for (int k = 0; k < 400 && !txn_done; k++) @(posedge clk);
    if (!txn_done) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      chk_en = 1'b0;
    end
    #1;
    set_idle();
    check({name, " op_count"}, got_ops.size(), exp_ops.size());
    for (int k = 0; k < got_ops.size() && k < exp_ops.size(); k++) begin
      check($sformatf("%s op%0d we", name, k), got_ops[k].we, exp_ops[k].we);
      check($sformatf("%s op%0d addr", name, k), got_ops[k].addr, exp_ops[k].addr);
      if (exp_ops[k].we) begin
        check($sformatf("%s op%0d wdata", name, k), got_ops[k].wdata, exp_ops[k].wdata);
        check($sformatf("%s op%0d wstrb", name, k), got_ops[k].wstrb, exp_ops[k].wstrb);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    set_idle();
    read_ena = 2'b01; addr[0] = 32'h100; mem_type[0] = 3'd4;
    #12;
    check("reset rv_active", read_valid, 2'b10);
    check("reset rdata", read_data[0] | read_data[1], 32'd0);
    check("reset bus", {bus_req, bus_we, bus_wstrb}, 6'd0);
    check("reset bus_addr_wdata", bus_addr | bus_wdata, 32'd0);
    read_ena = 2'b00;
    #1;
    check("reset rv_idle", read_valid, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run("lw_miss", 2'b00, 2'b01, 3'd4, 32'h100, 0, 3'd4, 0, 0, 0);
    check("lw_miss lit", obs_data[0], 32'hDEADBEEF);
    run("lw_hit", 2'b00, 2'b01, 3'd4, 32'h100, 0, 3'd4, 0, 0, 0);
    check("lw_hit no_bus", got_ops.size(), 0);

    run("lw_300", 2'b00, 2'b01, 3'd4, 32'h300, 0, 3'd4, 0, 0, 0);
    run("lb", 2'b00, 2'b01, 3'd0, 32'h303, 0, 3'd4, 0, 0, 0);
    check("lb lit", obs_data[0], 32'hFFFFFF80);
    run("lbu", 2'b00, 2'b10, 3'd4, 0, 0, 3'd1, 32'h303, 0, 0);
    check("lbu lit", obs_data[1], 32'h00000080);
    run("lh", 2'b00, 2'b01, 3'd2, 32'h302, 0, 3'd4, 0, 0, 0);
    check("lh lit", obs_data[0], 32'hFFFF80FF);
    run("lhu", 2'b00, 2'b10, 3'd4, 0, 0, 3'd3, 32'h300, 0, 0);
    check("lhu lit", obs_data[1], 32'h00007F01);

    run("sb_hazard", 2'b01, 2'b10, 3'd0, 32'h100, 32'h123456AA, 3'd4, 32'h100, 0, 0);
    check("sb_hazard data1", obs_data[1], 32'hDEADBEAA);
    if (got_ops.size() > 0) begin
      check("sb_hazard wstrb", got_ops[0].wstrb, 4'b0001);
      check("sb_hazard wdata", got_ops[0].wdata, 32'hAAAAAAAA);
    end
    run("sh_hazard", 2'b01, 2'b10, 3'd2, 32'h303, 32'h55551234, 3'd3, 32'h302, 0, 1);
    check("sh_hazard data1", obs_data[1], 32'h00001234);
    if (got_ops.size() > 0) check("sh_hazard wstrb", got_ops[0].wstrb, 4'b1100);

    run("dual_miss", 2'b00, 2'b11, 3'd4, 32'h400, 0, 3'd4, 32'h504, 0, 3);
    if (got_ops.size() == 2) begin
      check("dual_miss order0", got_ops[0].addr, 32'h400);
      check("dual_miss order1", got_ops[1].addr, 32'h504);
    end
    run("after_dual", 2'b00, 2'b01, 3'd4, 32'h600, 0, 3'd4, 0, 0, 0);
    run("dual_hit", 2'b00, 2'b11, 3'd4, 32'h100, 0, 3'd0, 32'h303, 0, 0);
    run("miss_then_hit", 2'b00, 2'b11, 3'd1, 32'h702, 0, 3'd4, 32'h504, 0, 2);

    run("sw_miss", 2'b01, 2'b00, 3'd4, 32'h200, 32'hCAFEF00D, 3'd4, 0, 0, 1);
    if (got_ops.size() > 0) check("sw_miss wstrb", got_ops[0].wstrb, 4'b1111);
    run("lw_after_sw", 2'b00, 2'b01, 3'd4, 32'h200, 0, 3'd4, 0, 0, 0);
    check("lw_after_sw bus", got_ops.size(), 1);
    check("lw_after_sw lit", obs_data[0], 32'hCAFEF00D);

    // Abandon an in-flight read with reset; the cache must come back empty.
    read_ena = 2'b01; mem_type[0] = 3'd4; addr[0] = 32'h704;
    ack_delay = 50;
    repeat (4) @(posedge clk);
    check("pre_rst bus_req", bus_req, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("rst bus_req", bus_req, 1'b0);
    check("rst bus_addr", bus_addr, 32'd0);
    set_idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(posedge clk); #1;
    run("post_rst_miss", 2'b00, 2'b01, 3'd4, 32'h100, 0, 3'd4, 0, 0, 0);
    check("post_rst bus", got_ops.size(), 1);
    check("post_rst lit", obs_data[0], 32'hDEADBEAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
